// File: rtl/pipelined_barrel_shifter_if.sv
// Purpose : valid/ready operation and result bus for pipelined_barrel_shifter.
// Signals : in_valid/in_ready handshake with in_data, in_shift, in_op, in_dir, in_tag;
//           out_valid/out_ready handshake with out_data, out_tag.
//           With PIPELINED_BARREL_SHIFTER_FLAGS_EN defined: out_zero, out_carry.
// Modports: master = producer of operations / consumer of results,
//           slave  = the shifter.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned TAG_WIDTH = 4
);
  localparam int unsigned SHIFT_WIDTH = $clog2(WIDTH);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic [1:0]             in_op;
  logic                   in_dir;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [TAG_WIDTH-1:0]   out_tag;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  logic                   out_zero;
  logic                   out_carry;

  modport master (
    output in_valid, in_data, in_shift, in_op, in_dir, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_carry
  );
  modport slave (
    input  in_valid, in_data, in_shift, in_op, in_dir, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_carry
  );
`else
  modport master (
    output in_valid, in_data, in_shift, in_op, in_dir, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_shift, in_op, in_dir, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Purpose : pipelined barrel shifter (logical / arithmetic / rotate / ones-fill,
//           left or right) with valid/ready flow control and a sideband tag.
// Ports   : clk, rst (async, active-high), bus (pipelined_barrel_shifter_if.slave).
// Params  : WIDTH (power of two >= 2), STAGES_PER_REG (mux stages per slice),
//           TAG_WIDTH. SHIFT_WIDTH = $clog2(WIDTH) is derived.
// Option  : define PIPELINED_BARREL_SHIFTER_FLAGS_EN to add out_zero/out_carry.
// Right shifts are done as left shifts on bit-reversed data: reversal on entry
// to slice 0 and on exit of the last slice.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned STAGES_PER_REG = 2,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned SHIFT_WIDTH = $clog2(WIDTH);
  localparam int unsigned NUM_SLICES  = (SHIFT_WIDTH + STAGES_PER_REG - 1) / STAGES_PER_REG;

  localparam logic [1:0] OP_ARI = 2'b01;
  localparam logic [1:0] OP_ROT = 2'b10;
  localparam logic [1:0] OP_ONE = 2'b11;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end
  if (STAGES_PER_REG < 1 || STAGES_PER_REG > SHIFT_WIDTH) begin : g_bad_stages
    $error("pipelined_barrel_shifter: STAGES_PER_REG must be in 1..SHIFT_WIDTH");
  end

  // Index k = values presented to slice k (0 = accepted operation).
  logic                   w_b_valid [NUM_SLICES];
  logic [WIDTH-1:0]       w_b_data  [NUM_SLICES];
  logic [SHIFT_WIDTH-1:0] w_b_shift [NUM_SLICES];
  logic [1:0]             w_b_op    [NUM_SLICES];
  logic                   w_b_dir   [NUM_SLICES];
  logic                   w_b_fill  [NUM_SLICES];
  logic [TAG_WIDTH-1:0]   w_b_tag   [NUM_SLICES];
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  logic                   w_b_carry [NUM_SLICES];
`endif
  logic [NUM_SLICES:0]    w_ready;

  // Entry: reverse for right shifts; fill bit fixed here (arith uses original MSB).
  assign w_b_valid[0] = bus.in_valid;
  assign w_b_data[0]  = bus.in_dir ? {<<{bus.in_data}} : bus.in_data;
  assign w_b_shift[0] = bus.in_shift;
  assign w_b_op[0]    = bus.in_op;
  assign w_b_dir[0]   = bus.in_dir;
  assign w_b_fill[0]  = (bus.in_op == OP_ONE) ||
                        ((bus.in_op == OP_ARI) && bus.in_dir && bus.in_data[WIDTH-1]);
  assign w_b_tag[0]   = bus.in_tag;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  assign w_b_carry[0] = 1'b0;
`endif

  assign w_ready[NUM_SLICES] = bus.out_ready;
  assign bus.in_ready        = w_ready[0];

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    localparam int unsigned LO = k * STAGES_PER_REG;
    localparam int unsigned HI = ((k + 1) * STAGES_PER_REG < SHIFT_WIDTH) ?
                                 (k + 1) * STAGES_PER_REG : SHIFT_WIDTH;
    localparam bit IS_LAST = (k == NUM_SLICES - 1);

    logic                   r_valid;
    logic [WIDTH-1:0]       r_data;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [WIDTH-1:0]       w_nxt_data;
    logic [WIDTH-1:0]       w_wrap;
    logic [SHIFT_WIDTH-1:0] w_sh_tmp;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    logic                   r_carry;
    logic                   w_nxt_carry;
`endif

    // A slice may load when empty or when its content moves on this cycle.
    assign w_ready[k] = !r_valid || w_ready[k+1];

    // Left-shift stages LO..HI-1; w_wrap holds the bits pushed out of the top.
    always_comb begin
      w_nxt_data = w_b_data[k];
      w_wrap     = '0;
      w_sh_tmp   = '0;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      w_nxt_carry = w_b_carry[k];
`endif
      for (int unsigned j = LO; j < HI; j++) begin
        w_sh_tmp = w_b_shift[k] >> j;
        if (w_sh_tmp[0]) begin
          w_wrap = w_nxt_data >> (WIDTH - (32'd1 << j));
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
          w_nxt_carry = w_wrap[0];
`endif
          w_nxt_data = (w_nxt_data << (32'd1 << j)) |
                       ((w_b_op[k] == OP_ROT) ? w_wrap :
                        w_b_fill[k] ? ~({WIDTH{1'b1}} << (32'd1 << j)) : '0);
        end
      end
      if (IS_LAST && w_b_dir[k]) begin
        w_nxt_data = {<<{w_nxt_data}};
      end
    end

    // Payload only updates when a real operation enters; bubbles just clear valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_ready[k]) begin
        r_valid <= w_b_valid[k];
        if (w_b_valid[k]) begin
          r_data <= w_nxt_data;
          r_tag  <= w_b_tag[k];
        end
      end
    end

`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_carry <= 1'b0;
      end else if (w_ready[k] && w_b_valid[k]) begin
        r_carry <= w_nxt_carry;
      end
    end
`endif

    if (IS_LAST) begin : g_out
      assign bus.out_valid = r_valid;
      assign bus.out_data  = r_data;
      assign bus.out_tag   = r_tag;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      logic r_zero;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_ready[k] && w_b_valid[k]) begin
          r_zero <= (w_nxt_data == '0);
        end
      end

      assign bus.out_zero  = r_zero;
      assign bus.out_carry = r_carry;
`endif
    end else begin : g_fwd
      logic [SHIFT_WIDTH-1:0] r_shift;
      logic [1:0]             r_op;
      logic                   r_dir;
      logic                   r_fill;

      // Control that later slices still need.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_shift <= '0;
          r_op    <= '0;
          r_dir   <= 1'b0;
          r_fill  <= 1'b0;
        end else if (w_ready[k] && w_b_valid[k]) begin
          r_shift <= w_b_shift[k];
          r_op    <= w_b_op[k];
          r_dir   <= w_b_dir[k];
          r_fill  <= w_b_fill[k];
        end
      end

      assign w_b_valid[k+1] = r_valid;
      assign w_b_data[k+1]  = r_data;
      assign w_b_shift[k+1] = r_shift;
      assign w_b_op[k+1]    = r_op;
      assign w_b_dir[k+1]   = r_dir;
      assign w_b_fill[k+1]  = r_fill;
      assign w_b_tag[k+1]   = r_tag;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      assign w_b_carry[k+1] = r_carry;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter at WIDTH=8, STAGES_PER_REG=1 (3 slices).
module tb_pipelined_barrel_shifter;
  localparam int unsigned W   = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned SPR = 1;
  localparam int unsigned TW  = 4;
  localparam int unsigned L   = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

  pipelined_barrel_shifter #(
    .WIDTH(W), .STAGES_PER_REG(SPR), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          carry;
    logic          zero;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: shift rules written directly with Verilog shift operators.
  function automatic logic [W-1:0] ref_data(input logic [W-1:0] x, input int n,
                                            input logic [1:0] op, input logic dir);
    logic [W-1:0] ones;
    ones = '1;
    if (n == 0) return x;
    case ({dir, op})
      3'b000, 3'b001: return x << n;
      3'b010:         return (x << n) | (x >> (W - n));
      3'b011:         return (x << n) | ~(ones << n);
      3'b100:         return x >> n;
      3'b101:         return W'($signed(x) >>> n);
      3'b110:         return (x >> n) | (x << (W - n));
      default:        return (x >> n) | ~(ones >> n);
    endcase
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] x, input int n, input logic dir);
    logic [W-1:0] t;
    if (n == 0) return 1'b0;
    t = dir ? (x >> (n - 1)) : (x >> (W - n));
    return t[0];
  endfunction

  task automatic set_op(input logic [W-1:0] d, input logic [SW-1:0] sh,
                        input logic [1:0] op, input logic dir, input logic [TW-1:0] tag);
    bus.in_data  = d;
    bus.in_shift = sh;
    bus.in_op    = op;
    bus.in_dir   = dir;
    bus.in_tag   = tag;
  endtask

  // One isolated operation: checks accept, latency, data, tag (and flags).
  task automatic run_single(input logic [W-1:0] d, input logic [SW-1:0] sh,
                            input logic [1:0] op, input logic dir,
                            input logic [TW-1:0] tag, input logic [W-1:0] exp_d);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_op(d, sh, op, dir, tag);
    bus.in_valid = 1'b1;
    #1 chk("single_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'(L));
    chk("single_data", 32'(bus.out_data), 32'(exp_d));
    chk("single_tag", 32'(bus.out_tag), 32'(tag));
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    chk("single_carry", 32'(bus.out_carry), 32'(ref_carry(d, int'(sh), dir)));
    chk("single_zero", 32'(bus.out_zero), 32'(exp_d == '0));
`endif
    @(posedge clk);
  endtask

  // Streamed traffic against a scoreboard queue; mode 0 = fixed pattern, 1 = random.
  task automatic run_stream(input int n_ops, input bit rand_mode);
    int            sent;
    int            cyc;
    bit            pend;
    bit            prev_stall;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;
    logic [W-1:0]  d;
    logic [SW-1:0] sh;
    logic [1:0]    op;
    logic          dir;
    exp_t          e;
    sent = 0; cyc = 0; pend = 0; prev_stall = 0;
    prev_data = '0; prev_tag = '0; d = '0; sh = '0; op = '0; dir = 1'b0;
    while ((sent < n_ops || q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      if (!pend && sent < n_ops && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        d   = W'($urandom);
        sh  = SW'($urandom);
        op  = 2'($urandom);
        dir = 1'($urandom);
        set_op(d, sh, op, dir, TW'(sent));
        pend = 1;
      end
      bus.in_valid  = pend;
      bus.out_ready = rand_mode ? ($urandom_range(0, 2) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == L && !bus.out_ready)));
      if (prev_stall) begin
        chk("stall_data", 32'(bus.out_data), 32'(prev_data));
        chk("stall_tag", 32'(bus.out_tag), 32'(prev_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("stream_data", 32'(bus.out_data), 32'(e.data));
          chk("stream_tag", 32'(bus.out_tag), 32'(e.tag));
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
          chk("stream_carry", 32'(bus.out_carry), 32'(e.carry));
          chk("stream_zero", 32'(bus.out_zero), 32'(e.zero));
`endif
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        e.data  = ref_data(d, int'(sh), op, dir);
        e.tag   = TW'(sent);
        e.carry = ref_carry(d, int'(sh), dir);
        e.zero  = (e.data == '0);
        q.push_back(e);
        sent++;
        pend = 0;
      end
      cyc++;
    end
    chk("stream_drained", 32'(q.size()), 32'd0);
    chk("stream_sent", 32'(sent), 32'(n_ops));
    bus.in_valid = 1'b0;
    q.delete();
  endtask

  initial begin
    int stale;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op('0, '0, 2'b00, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases with hand-computed results.
    run_single(8'h96, 3'd3, 2'b00, 1'b0, 4'h3, 8'hB0);
    run_single(8'h96, 3'd2, 2'b01, 1'b1, 4'h4, 8'hE5);
    run_single(8'h96, 3'd2, 2'b10, 1'b1, 4'h5, 8'hA5);
    run_single(8'h96, 3'd4, 2'b11, 1'b0, 4'h6, 8'h6F);
    run_single(8'h96, 3'd7, 2'b10, 1'b0, 4'h7, 8'h4B);
    run_single(8'h81, 3'd1, 2'b00, 1'b0, 4'h8, 8'h02);
    run_single(8'h80, 3'd1, 2'b00, 1'b0, 4'h9, 8'h00);
    for (int op = 0; op < 4; op++) begin
      for (int dir = 0; dir < 2; dir++) begin
        run_single(8'h5A, 3'd0, 2'(op), 1'(dir), TW'(op * 2 + dir), 8'h5A);
      end
    end

    // Eight back-to-back ops under the 1,0,0,1 out_ready pattern, then random traffic.
    run_stream(8, 1'b0);
    run_stream(300, 1'b1);

    // Reset with three operations in flight.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(W'($urandom), SW'($urandom), 2'($urandom), 1'($urandom), TW'(i));
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1 chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_out_tag", 32'(bus.out_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    run_single(8'h96, 3'd3, 2'b00, 1'b0, 4'hC, 8'hB0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
